// File: rtl/block_hit_writer.sv
// Brick-hit read-modify-write client for block_memory port 1.
// Queues hits, decrements brick strength, tracks score and bricks left.
module block_hit_writer #(
   parameter int ROW_W      = 5,
   parameter int COL_W      = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int POINTS     = 10,
   parameter int SCORE_W    = 16,
   parameter int HARD_VAL   = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               hit_valid,
   input  logic [ROW_W-1:0]   hit_row,
   input  logic [COL_W-1:0]   hit_col,
   output logic               hit_ready,
   input  logic               load_count,
   input  logic [9:0]         load_value,
   output logic [ROW_W-1:0]   mem_row,
   output logic [COL_W-1:0]   mem_col,
   output logic [1:0]         mem_func,
   output logic [3:0]         mem_wdata,
   input  logic [3:0]         mem_rdata,
   input  logic               mem_busy,
   output logic               destroyed,
   output logic [SCORE_W-1:0] score,
   output logic [9:0]         blocks_left,
   output logic               all_clear
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [1:0] F_IDLE = 2'b00;
   localparam logic [1:0] F_RD   = 2'b01;
   localparam logic [1:0] F_WR   = 2'b10;
   localparam logic [3:0] HARD   = 4'(HARD_VAL);
   localparam logic [SCORE_W-1:0] S_MAX = '1;
   localparam logic [SCORE_W-1:0] S_PTS = SCORE_W'(POINTS);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT
   } state_t;

   state_t state;

   logic [ROW_W-1:0] fifo_row [FIFO_DEPTH];
   logic [COL_W-1:0] fifo_col [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             push;
   logic             pop;
   logic             loaded;

   assign push = hit_valid & hit_ready;
   assign pop  = (state == IDLE) && (count != '0);

   always_comb begin
      count_next = count;
      count_next = count + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_row[wr_ptr] <= hit_row;
         fifo_col[wr_ptr] <= hit_col;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         hit_ready   <= 1'b1;
         mem_row     <= '0;
         mem_col     <= '0;
         mem_func    <= F_IDLE;
         mem_wdata   <= '0;
         destroyed   <= 1'b0;
         score       <= '0;
         blocks_left <= '0;
         loaded      <= 1'b0;
         all_clear   <= 1'b0;
      end else begin
         count     <= count_next;
         hit_ready <= (count_next != FULL_CNT);
         destroyed <= 1'b0;
         all_clear <= loaded && (blocks_left == '0) &&
                      (state == IDLE) && (count == '0);
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;

         unique case (state)
            IDLE: begin
               if (pop) begin
                  mem_row  <= fifo_row[rd_ptr];
                  mem_col  <= fifo_col[rd_ptr];
                  mem_func <= F_RD;
                  state    <= RD_REQ;
               end
            end
            RD_REQ: begin
               if (!mem_busy) begin
                  mem_func <= F_IDLE;
                  state    <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (!mem_busy) begin
                  // empty and indestructible bricks need no write
                  if (mem_rdata == 4'd0 || mem_rdata == HARD) begin
                     state <= IDLE;
                  end else begin
                     mem_wdata <= mem_rdata - 4'd1;
                     mem_func  <= F_WR;
                     state     <= WR_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (!mem_busy) begin
                  mem_func <= F_IDLE;
                  state    <= WR_WAIT;
               end
            end
            WR_WAIT: begin
               if (!mem_busy) begin
                  state <= IDLE;
                  if (mem_wdata == 4'd0) begin
                     destroyed <= 1'b1;
                     if (score > S_MAX - S_PTS)
                        score <= S_MAX;
                     else
                        score <= score + S_PTS;
                     if (blocks_left != '0)
                        blocks_left <= blocks_left - 10'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // a stage-start load overrides a coincident destroy
         if (load_count) begin
            blocks_left <= load_value;
            loaded      <= 1'b1;
         end
      end
   end

endmodule
